// File: rtl/ex_muldiv.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage: mult/multu/div/divu
// run for a fixed number of busy cycles, mthi/mtlo write HI/LO directly.
module ex_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0]      a_ext, b_ext, prod;
  logic signed [WIDTH-1:0] sa, sb, sq, sr;
  logic [WIDTH-1:0]        b_safe, uq, ur;
  logic                    div_zero, div_ovf;
  logic [WIDTH-1:0]        res_hi, res_lo;

  // Result datapath works only on the latched operands, so a/b may change freely during RUN.
  // Forcing the divisor to 1 on overflow yields lo = a, hi = 0 without a separate mux.
  always_comb begin
    a_ext    = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext    = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod     = a_ext * b_ext;
    div_zero = (b_q == '0);
    div_ovf  = !op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    b_safe   = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
    sa       = $signed(a_q);
    sb       = $signed(b_safe);
    sq       = sa / sb;
    sr       = sa % sb;
    uq       = a_q / b_safe;
    ur       = a_q % b_safe;
    res_hi   = prod[2*WIDTH-1:WIDTH];
    res_lo   = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (div_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end else if (op_q[0]) begin
        res_hi = ur;
        res_lo = uq;
      end else begin
        res_hi = $unsigned(sr);
        res_lo = $unsigned(sq);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
              state_d = RUN;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Cancel wins even on the completion edge: no write, no done.
        if (cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic HI/LO reference model.
module tb_ex_muldiv;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [31:0] model_hi, model_lo;
  int checks = 0;
  int passes = 0;

  ex_muldiv #(.WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: the architectural HI/LO result computed with wide integer arithmetic.
  function automatic void refResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eh, output logic [31:0] el);
    longint          sp, q, r;
    longint unsigned up;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        eh = sp[63:32]; el = sp[31:0];
      end
      3'd1: begin
        up = {32'b0, x} * {32'b0, y};
        eh = up[63:32]; el = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = x;
        end else if (o == 3'd2) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
  endfunction

  // Called at a negedge; drives one start and follows the operation to its end.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit start_cancel, input int cancel_at, input int poke_at);
    logic [31:0] eh, el;
    int n, k;
    start = 1'b1; op = o; a = x; b = y; cancel = start_cancel;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; a = $urandom; b = $urandom;
    if (start_cancel || o >= 3'd6 || o == 3'd4 || o == 3'd5) begin
      if (!start_cancel && o == 3'd4) model_hi = x;
      if (!start_cancel && o == 3'd5) model_lo = x;
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
      checkOutput("idle_hi", hi, model_hi);
      checkOutput("idle_lo", lo, model_lo);
      return;
    end
    refResult(o, x, y, eh, el);
    n = o[1] ? DIV_N : MULT_N;
    k = 0;
    while (busy && k < 300) begin
      k++;
      checkOutput("run_hi_hold", hi, model_hi);
      checkOutput("run_lo_hold", lo, model_lo);
      checkOutput("run_done", 32'(done), 32'd0);
      if (k == poke_at) begin
        start = 1'b1; op = 3'd4; a = $urandom;
      end else begin
        start = 1'b0;
      end
      cancel = (k == cancel_at);
      a = (k == poke_at) ? a : $urandom;
      @(negedge clk);
    end
    start = 1'b0; cancel = 1'b0;
    if (cancel_at != 0 && cancel_at <= n) begin
      checkOutput("cancel_cycles", k, cancel_at);
      checkOutput("cancel_done", 32'(done), 32'd0);
      checkOutput("cancel_hi", hi, model_hi);
      checkOutput("cancel_lo", lo, model_lo);
      @(negedge clk);
      checkOutput("cancel_done2", 32'(done), 32'd0);
    end else begin
      model_hi = eh;
      model_lo = el;
      checkOutput("busy_cycles", k, n);
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("busy_after", 32'(busy), 32'd0);
      checkOutput("res_hi", hi, model_hi);
      checkOutput("res_lo", lo, model_lo);
      @(negedge clk);
      checkOutput("done_drop", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    bit          sc;
    int          ca, pk, n;

    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
    model_hi = '0; model_lo = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0, 0);
    checkOutput("multu_hi_const", hi, 32'h0000_0001);
    checkOutput("multu_lo_const", lo, 32'hFFFF_FFFE);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
    checkOutput("div_lo_const", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi_const", hi, 32'hFFFF_FFFF);
    applyStimulus(3'd3, 32'd7, 32'd0, 1'b0, 0, 0);
    checkOutput("divu0_lo_const", lo, 32'hFFFF_FFFF);
    checkOutput("divu0_hi_const", hi, 32'h0000_0007);
    applyStimulus(3'd0, 32'h8765_4321, 32'h1234_5678, 1'b0, 0, 2);
    applyStimulus(3'd4, 32'hAAAA_0001, 32'd0, 1'b0, 0, 0);
    applyStimulus(3'd5, 32'h5555_0002, 32'd0, 1'b0, 0, 0);
    applyStimulus(3'd2, 32'd1000, 32'd7, 1'b0, 4, 0);
    applyStimulus(3'd3, 32'd1000, 32'd7, 1'b0, DIV_N, 0);
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0);
    checkOutput("ovf_lo_const", lo, 32'h8000_0000);
    checkOutput("ovf_hi_const", hi, 32'h0000_0000);
    applyStimulus(3'd5, 32'd5, 32'd0, 1'b0, 0, 0);
    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd3, 1'b0, 0, 0);
    applyStimulus(3'd0, 32'd3, 32'd4, 1'b1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      n  = o[1] ? DIV_N : MULT_N;
      sc = ($urandom_range(0, 7) == 0);
      ca = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0;
      pk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      applyStimulus(o, x, y, sc, ca, pk);
    end

    applyStimulus(3'd4, 32'h1357_9BDF, 32'd0, 1'b0, 0, 0);
    start = 1'b1; op = 3'd2; a = 32'd99; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_hi = '0;
    model_lo = '0;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_hi", hi, 32'd0);
    checkOutput("async_lo", lo, 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(3'd1, 32'h0001_0000, 32'h0003_0000, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
